reg_file_param: RTL and testbench
=================================

// Module: reg_file_param
// PURPOSE
//  Parametrised multi-register storage for the Simple CPU datapath: DEPTH words of WIDTH bits,
//  one masked write port, two independent read ports (A/B operand fetch).
//  Adds byte-lane write masks, optional hard-wired zero register, optional write-to-read bypass,
//  synchronous clear-all and out-of-range write detection.
//  Sits between the decode stage (addresses) and the ALU (operands); writeback drives the write port.
// PARAMETERS
//  WIDTH      16   bits per word; must be a multiple of 8
//  DEPTH      16   number of words; any value >= 2 (need not be a power of two)
//  ADDR_W     4    address width; must satisfy 2**ADDR_W >= DEPTH
//  ZERO_REG   0    1: word 0 reads as 0 and ignores writes
//  BYPASS     1    1: a same-cycle write is visible on the read ports (write-through)
//  RESET_VAL  0    value loaded into every word on reset and on clr
// PORTS
//  clk        in   1             rising-edge clock
//  reset      in   1             asynchronous, active-low reset (0 = in reset)
//  clr        in   1             synchronous clear-all: every word <= RESET_VAL
//  wr_en      in   1             write strobe
//  wr_addr    in   ADDR_W        write word address
//  wr_data    in   WIDTH         write data
//  wr_mask    in   WIDTH/8       byte-lane enables; bit i covers wr_data[8i+7:8i]
//  rd_addr_a  in   ADDR_W        read port A address
//  rd_data_a  out  WIDTH         read port A data (combinational)
//  rd_addr_b  in   ADDR_W        read port B address
//  rd_data_b  out  WIDTH         read port B data (combinational)
//  wr_err     out  1             registered 1-cycle pulse: previous-cycle write was out of range
// BEHAVIOUR
//  - Reset (reset=0, async): all words <= RESET_VAL, wr_err <= 0, immediately (no clk edge needed).
//    While in reset, rd_data_* = RESET_VAL (0 for word 0 if ZERO_REG=1); writes and clr are ignored.
//  - Priority at each rising clk edge: reset > clr > write. clr=1 with wr_en=1: write is dropped.
//  - Write: wr_en=1, wr_addr<DEPTH -> for each i with wr_mask[i]=1, word[wr_addr] byte i <= wr_data byte i;
//    unmasked bytes hold. wr_mask=0 -> no change, not an error. Latency 1 edge.
//  - ZERO_REG=1: writes to address 0 are silently dropped (no wr_err); reads of address 0 return 0.
//  - Out of range: wr_en=1, wr_addr>=DEPTH -> no word changes; wr_err=1 for exactly the next cycle.
//    wr_err is 0 in all other cycles, including clr cycles (clr suppresses the error).
//    Read of address >= DEPTH returns 0.
//  - Reads: rd_data_x = word[rd_addr_x], zero-latency combinational; ports fully independent;
//    A and B may address the same word.
//  - BYPASS=1: if wr_en=1, clr=0, wr_addr==rd_addr_x, address valid and writable, rd_data_x returns
//    the merged value (masked new bytes + stored unmasked bytes) in the same cycle.
//    If clr=1: rd_data_x returns RESET_VAL for every valid address (0 for word 0 if ZERO_REG=1).
//  - BYPASS=0: reads always return stored contents; new data is visible the cycle after the edge.
//  - Reset asserted mid-write: write is lost, reset value wins.
// TESTING
//  1. reset=0 with words preloaded -> all rd_data = RESET_VAL without clk edge; wr_err=0.
//  2. write addr 5 = 16'hBEEF, mask 2'b11; next cycle rd_addr_a=5 -> 16'hBEEF; then write
//     16'h1234, mask 2'b01 -> reads 16'hBE34.
//  3. BYPASS=1: wr_en addr 3 = 16'hA5A5 and rd_addr_b=3 in the same cycle -> rd_data_b=16'hA5A5
//     before the edge; BYPASS=0 -> old value until after the edge.
//  4. DEPTH=12: write addr 13 -> no word changes; wr_err=1 for one cycle only;
//     read addr 13 -> 0.
//  5. ZERO_REG=1: write 16'hFFFF to addr 0 -> rd_data_a(addr 0)=0; wr_err stays 0.
//  6. clr=1 together with wr_en=1 to addr 7 -> all words RESET_VAL after the edge; addr 7 not written;
//     no wr_err.

Source files
------------

// File: rtl/reg_file_param.sv
// Parametrised register file: one byte-masked write port, two combinational
// read ports, optional zero register, optional write-through bypass.
module reg_file_param #(
  parameter int              WIDTH     = 16,
  parameter int              DEPTH     = 16,
  parameter int              ADDR_W    = 4,
  parameter int              ZERO_REG  = 0,
  parameter int              BYPASS    = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [WIDTH/8-1:0]   wr_mask,
  input  logic [ADDR_W-1:0]    rd_addr_a,
  output logic [WIDTH-1:0]     rd_data_a,
  input  logic [ADDR_W-1:0]    rd_addr_b,
  output logic [WIDTH-1:0]     rd_data_b,
  output logic                 wr_err
);

  localparam int          NB      = WIDTH / 8;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic              wr_err_q;
  logic              wr_err_d;

  logic              wr_in_range;
  logic              wr_writable;
  logic [ADDR_W-1:0] wr_idx;
  logic [WIDTH-1:0]  wr_bitmask;
  logic [WIDTH-1:0]  wr_merged;

  logic [ADDR_W-1:0] rd_addr [2];
  logic [WIDTH-1:0]  rd_data [2];

  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;
  assign rd_data_a  = rd_data[0];
  assign rd_data_b  = rd_data[1];
  assign wr_err     = wr_err_q;

  // Decode the write address and merge new bytes over the stored word.
  always_comb begin
    wr_in_range = 32'(wr_addr) < DEPTH_U;
    wr_writable = wr_in_range &&
                  !((ZERO_REG != 0) && (wr_addr == '0));
    wr_idx      = wr_in_range ? wr_addr : '0;
    wr_bitmask  = '0;
    for (int i = 0; i < NB; i++) begin
      wr_bitmask[8*i +: 8] = {8{wr_mask[i]}};
    end
    wr_merged = (wr_data & wr_bitmask) |
                (mem_q[wr_idx] & ~wr_bitmask);
  end

  // Next-state storage: clear beats write; bad addresses only flag an error.
  always_comb begin
    mem_d    = mem_q;
    wr_err_d = 1'b0;
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] = RESET_VAL;
      end
    end else if (wr_en) begin
      wr_err_d = !wr_in_range;
      if (wr_writable) begin
        mem_d[wr_idx] = wr_merged;
      end
    end
  end

  // Storage and error flag, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RESET_VAL;
      end
      wr_err_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_err_q <= wr_err_d;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic              in_rng;
    logic [ADDR_W-1:0] idx;

    assign in_rng = 32'(rd_addr[p]) < DEPTH_U;
    assign idx    = in_rng ? rd_addr[p] : '0;

    // Read mux: range/zero-reg gating, reset override, then bypass.
    always_comb begin
      rd_data[p] = mem_q[idx];
      if (!in_rng ||
          ((ZERO_REG != 0) && (rd_addr[p] == '0))) begin
        rd_data[p] = '0;
      end else if (!reset) begin
        rd_data[p] = RESET_VAL;
      end else if ((BYPASS != 0) && clr) begin
        rd_data[p] = RESET_VAL;
      end else if ((BYPASS != 0) && wr_en &&
                   wr_writable && (wr_addr == rd_addr[p])) begin
        rd_data[p] = wr_merged;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: two configurations driven in parallel
// and compared every cycle against a behavioural model.
module tb_reg_file_param;

  localparam int          D0  = 16;
  localparam int          D1  = 12;
  localparam logic [15:0] RV0 = 16'h0000;
  localparam logic [15:0] RV1 = 16'h5A00;

  logic        clk = 1'b0;
  logic        reset;
  logic        clr;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [1:0]  wr_mask;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;
  logic [15:0] rda0, rdb0, rda1, rdb1;
  logic        err0, err1;

  int errors = 0;
  int checks = 0;

  logic [15:0] m0 [16];
  logic [15:0] m1 [16];
  logic        e0, e1;

  always #5 clk = ~clk;

  reg_file_param #(
    .WIDTH(16), .DEPTH(D0), .ADDR_W(4),
    .ZERO_REG(0), .BYPASS(1), .RESET_VAL(RV0)
  ) u0 (
    .clk(clk), .reset(reset), .clr(clr),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_addr_a(rd_addr_a), .rd_data_a(rda0),
    .rd_addr_b(rd_addr_b), .rd_data_b(rdb0),
    .wr_err(err0)
  );

  reg_file_param #(
    .WIDTH(16), .DEPTH(D1), .ADDR_W(4),
    .ZERO_REG(1), .BYPASS(0), .RESET_VAL(RV1)
  ) u1 (
    .clk(clk), .reset(reset), .clr(clr),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_addr_a(rd_addr_a), .rd_data_a(rda1),
    .rd_addr_b(rd_addr_b), .rd_data_b(rdb1),
    .wr_err(err1)
  );

  function automatic logic [15:0] merge(
    input logic [15:0] old,
    input logic [15:0] d,
    input logic [1:0]  mk
  );
    logic [15:0] r;
    r = old;
    for (int b = 0; b < 2; b++) begin
      if (mk[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  // Expected read value for instance 0 or 1 at the current inputs.
  function automatic logic [15:0] exp_rd(input int inst, input logic [3:0] a);
    int          dep;
    bit          zr;
    bit          byp;
    logic [15:0] rv;
    logic [15:0] st;
    dep = inst ? D1 : D0;
    zr  = (inst == 1);
    byp = (inst == 0);
    rv  = inst ? RV1 : RV0;
    st  = inst ? m1[a] : m0[a];
    if (int'(a) >= dep) return 16'h0;
    if (zr && a == 4'd0) return 16'h0;
    if (!reset) return rv;
    if (byp && clr) return rv;
    if (byp && wr_en && wr_addr == a) return merge(st, wr_data, wr_mask);
    return st;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m0[i] = RV0;
      m1[i] = RV1;
    end
    e0 = 1'b0;
    e1 = 1'b0;
  endtask

  task automatic model_edge();
    if (!reset || clr) begin
      model_reset();
    end else begin
      e0 = wr_en && (int'(wr_addr) >= D0);
      e1 = wr_en && (int'(wr_addr) >= D1);
      if (wr_en) begin
        if (int'(wr_addr) < D0)
          m0[wr_addr] = merge(m0[wr_addr], wr_data, wr_mask);
        if (int'(wr_addr) < D1 && wr_addr != 4'd0)
          m1[wr_addr] = merge(m1[wr_addr], wr_data, wr_mask);
      end
    end
  endtask

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("u0_rd_a", rda0, exp_rd(0, rd_addr_a));
    chk("u0_rd_b", rdb0, exp_rd(0, rd_addr_b));
    chk("u1_rd_a", rda1, exp_rd(1, rd_addr_a));
    chk("u1_rd_b", rdb1, exp_rd(1, rd_addr_b));
    chk("u0_err", {15'h0, err0}, {15'h0, e0});
    chk("u1_err", {15'h0, err1}, {15'h0, e1});
  endtask

  task automatic drive(input logic c, input logic we, input logic [3:0] wa,
                       input logic [15:0] wd, input logic [1:0] wm,
                       input logic [3:0] ra, input logic [3:0] rb);
    clr       = c;
    wr_en     = we;
    wr_addr   = wa;
    wr_data   = wd;
    wr_mask   = wm;
    rd_addr_a = ra;
    rd_addr_b = rb;
    #1;
    check_all();
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic set_reset(input logic v);
    reset = v;
    if (!v) model_reset();
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b0;
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check_all();
    chk("rst_err0", {15'h0, err0}, 16'h0);
    chk("rst_rd1", rdb1, 16'h0);
    set_reset(1'b1);

    drive(0, 1, 4'd5, 16'hBEEF, 2'b11, 4'd5, 4'd2);
    step();
    drive(0, 0, 0, 0, 0, 4'd5, 4'd5);
    chk("lit_beef0", rda0, 16'hBEEF);
    chk("lit_beef1", rdb1, 16'hBEEF);
    drive(0, 1, 4'd5, 16'h1234, 2'b01, 4'd5, 4'd5);
    step();
    drive(0, 0, 0, 0, 0, 4'd5, 4'd5);
    chk("lit_be34_0", rda0, 16'hBE34);
    chk("lit_be34_1", rda1, 16'hBE34);

    drive(0, 1, 4'd3, 16'hA5A5, 2'b11, 4'd0, 4'd3);
    chk("lit_byp0", rdb0, 16'hA5A5);
    chk("lit_nobyp1", rdb1, RV1);
    step();
    drive(0, 0, 0, 0, 0, 4'd0, 4'd3);
    chk("lit_after1", rdb1, 16'hA5A5);

    drive(0, 1, 4'd13, 16'h7777, 2'b11, 4'd13, 4'd0);
    chk("lit_oor_rd", rda1, 16'h0);
    step();
    chk("lit_err1", {15'h0, err1}, 16'h1);
    drive(0, 0, 0, 0, 0, 4'd13, 4'd0);
    step();
    chk("lit_err0", {15'h0, err1}, 16'h0);

    drive(0, 1, 4'd0, 16'hFFFF, 2'b11, 4'd0, 4'd0);
    step();
    chk("lit_zr_err", {15'h0, err1}, 16'h0);
    chk("lit_zr_rd", rda1, 16'h0);

    drive(1, 1, 4'd7, 16'h1111, 2'b11, 4'd7, 4'd5);
    chk("lit_clr_byp", rda0, RV0);
    step();
    drive(0, 0, 0, 0, 0, 4'd7, 4'd5);
    chk("lit_clr7", rda0, 16'h0);
    chk("lit_clr5", rdb1, RV1);

    drive(0, 1, 4'd5, 16'hCAFE, 2'b11, 4'd5, 4'd5);
    step();
    drive(0, 1, 4'd5, 16'h9999, 2'b11, 4'd5, 4'd5);
    set_reset(1'b0);
    chk("lit_arst0", rda0, RV0);
    chk("lit_arst1", rdb1, RV1);
    step();
    set_reset(1'b1);

    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(15) == 0), $urandom_range(1),
            4'($urandom_range(15)), 16'($urandom),
            2'($urandom_range(3)), 4'($urandom_range(15)),
            4'($urandom_range(15)));
      if ($urandom_range(40) == 0) set_reset(1'b0);
      step();
      if (!reset) set_reset(1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
